// File: rtl/dbg_pkg.sv
// Shared definitions for the retire-side debug trace logic: controller states
// and the halt-cause encoding reported to the debug agent.
package dbg_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        DUMP   = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
    localparam logic [1:0] CAUSE_INVALID = 2'd2;

endpackage

// File: rtl/trace_ram.sv
// Ring storage for retired {pc, inst} pairs: one synchronous write port and
// one asynchronous read port so the dump path presents data in the same cycle.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/retire_trace_buffer.sv
// Records the last DEPTH retired instructions, halts the core on ebreak or an
// illegal instruction, and streams the history oldest-first while halted.
module retire_trace_buffer
    import dbg_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid,
    input  logic [XLEN-1:0]            pc,
    input  logic [XLEN-1:0]            inst,
    input  logic                       is_ebreak,
    input  logic                       is_invalid,
    output logic                       halt,
    output logic [1:0]                 halt_cause,
    output logic [XLEN-1:0]            halt_pc,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       dump_start,
    input  logic                       resume,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic [XLEN-1:0]            dump_pc,
    output logic [XLEN-1:0]            dump_inst,
    output logic                       dump_last
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    state_t            state;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     remaining;
    logic [2*XLEN-1:0] rd_data;
    logic              ram_we;
    logic              handshake;

    assign ram_we    = (state == RUN) && valid;
    assign handshake = dump_valid && dump_ready;

    trace_ram #(
        .DEPTH(DEPTH),
        .WIDTH(2 * XLEN)
    ) u_trace_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(wptr),
        .wdata({pc, inst}),
        .raddr(rptr),
        .rdata(rd_data)
    );

    // Dump outputs are gated so they read zero outside DUMP, including during reset.
    assign dump_valid = (state == DUMP);
    assign dump_pc    = dump_valid ? rd_data[2*XLEN-1:XLEN] : '0;
    assign dump_inst  = dump_valid ? rd_data[XLEN-1:0]      : '0;
    assign dump_last  = dump_valid && (remaining == CW'(1));

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            remaining  <= '0;
            halt       <= 1'b0;
            halt_cause <= CAUSE_NONE;
            halt_pc    <= '0;
        end else if (state != RUN && resume) begin
            // Resume beats dump_start and aborts a dump in flight; wptr is kept.
            state      <= RUN;
            count      <= '0;
            halt       <= 1'b0;
            halt_cause <= CAUSE_NONE;
            halt_pc    <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (valid) begin
                        wptr <= wptr + PW'(1);
                        if (count != CW'(DEPTH)) begin
                            count <= count + CW'(1);
                        end
                        if (is_ebreak || is_invalid) begin
                            state      <= HALTED;
                            halt       <= 1'b1;
                            halt_cause <= is_invalid ? CAUSE_INVALID : CAUSE_EBREAK;
                            halt_pc    <= pc;
                        end
                    end
                end
                HALTED: begin
                    if (dump_start && count != '0) begin
                        state     <= DUMP;
                        // A full ring has count[PW-1:0] == 0, so the oldest entry sits at wptr.
                        rptr      <= wptr - count[PW-1:0];
                        remaining <= count;
                    end
                end
                DUMP: begin
                    if (handshake) begin
                        rptr      <= rptr + PW'(1);
                        remaining <= remaining - CW'(1);
                        if (remaining == CW'(1)) begin
                            state <= HALTED;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Randomized and directed bench for retire_trace_buffer with a queue-based
// reference model and a decoupled dump-stream scoreboard.
module tb_retire_trace_buffer;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            valid = 1'b0;
    logic [XLEN-1:0] pc = '0;
    logic [XLEN-1:0] inst = '0;
    logic            is_ebreak = 1'b0;
    logic            is_invalid = 1'b0;
    logic            halt;
    logic [1:0]      halt_cause;
    logic [XLEN-1:0] halt_pc;
    logic [CW-1:0]   count;
    logic            dump_start = 1'b0;
    logic            resume = 1'b0;
    logic            dump_valid;
    logic            dump_ready = 1'b0;
    logic [XLEN-1:0] dump_pc;
    logic [XLEN-1:0] dump_inst;
    logic            dump_last;

    retire_trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .pc        (pc),
        .inst      (inst),
        .is_ebreak (is_ebreak),
        .is_invalid(is_invalid),
        .halt      (halt),
        .halt_cause(halt_cause),
        .halt_pc   (halt_pc),
        .count     (count),
        .dump_start(dump_start),
        .resume    (resume),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_pc   (dump_pc),
        .dump_inst (dump_inst),
        .dump_last (dump_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          last;
    } exp_t;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;

    // Reference model: history as a bounded queue plus halt bookkeeping.
    ent_t        hist[$];
    exp_t        exp_q[$];
    bit          m_halted = 1'b0;
    logic [1:0]  m_cause  = 2'd0;
    logic [31:0] m_hpc    = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_release();
        hist.delete();
        m_halted = 1'b0;
        m_cause  = 2'd0;
        m_hpc    = '0;
    endtask

    // Monitor: compares every accepted dump beat and checks stability under backpressure.
    bit          held = 1'b0;
    logic [31:0] held_pc, held_inst;
    bit          held_last;

    always @(negedge clk) begin
        if (reset && valid && halt) begin
            total++;
            bad++;
            $display("FAIL retire_while_halted: valid=1 seen with halt=%0d", halt);
        end
        if (reset && dump_valid) begin
            if (held) begin
                check("hold_pc", dump_pc, held_pc);
                check("hold_inst", dump_inst, held_inst);
                check("hold_last", dump_last, held_last);
            end
            if (dump_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_dump: got pc %0h, expected no entry", dump_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("dump_pc", dump_pc, e.pc);
                    check("dump_inst", dump_inst, e.inst);
                    check("dump_last", dump_last, e.last);
                end
                hs_cnt++;
            end else begin
                held      = 1'b1;
                held_pc   = dump_pc;
                held_inst = dump_inst;
                held_last = dump_last;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] p, input logic [31:0] i, input bit eb, input bit inv);
        valid = 1'b1; pc = p; inst = i; is_ebreak = eb; is_invalid = inv;
        tick();
        valid = 1'b0; is_ebreak = 1'b0; is_invalid = 1'b0;
        hist.push_back('{p, i});
        if (hist.size() > DEPTH) hist.delete(0);
        if (eb || inv) begin
            m_halted = 1'b1;
            m_cause  = inv ? 2'd2 : 2'd1;
            m_hpc    = p;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_halt"}, halt, m_halted);
        check({tag, "_cause"}, halt_cause, m_cause);
        check({tag, "_halt_pc"}, halt_pc, m_hpc);
        check({tag, "_count"}, count, hist.size());
        check({tag, "_dump_valid"}, dump_valid, 0);
        check({tag, "_dump_pc"}, dump_pc, 0);
    endtask

    task automatic do_resume();
        resume = 1'b1;
        tick();
        resume = 1'b0;
        if (m_halted) model_release();
    endtask

    // kind 0: always ready, 1: fixed 1,0,0,1,0,1,1 pattern, 2: random. abort_after<0 disables abort.
    task automatic do_dump(input string tag, input int kind, input int abort_after);
        int    start;
        int    n;
        int    cyc;
        bit    accepted;
        bit    did_abort;
        bit    pat[7];
        pat = '{1, 0, 0, 1, 0, 1, 1};
        start     = hs_cnt;
        n         = hist.size();
        accepted  = m_halted && n > 0;
        did_abort = 1'b0;
        if (accepted) begin
            for (int k = 0; k < n; k++) exp_q.push_back('{hist[k].pc, hist[k].inst, k == n - 1});
        end
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        check({tag, "_dump_entered"}, dump_valid, accepted);
        cyc = 0;
        while (dump_valid && cyc < 300) begin
            if (abort_after >= 0 && hs_cnt - start >= abort_after) begin
                resume     = 1'b1;
                dump_ready = 1'b0;
                did_abort  = 1'b1;
            end else begin
                case (kind)
                    0:       dump_ready = 1'b1;
                    1:       dump_ready = pat[cyc % 7];
                    default: dump_ready = $urandom_range(0, 2) != 0;
                endcase
            end
            tick();
            dump_ready = 1'b0;
            resume     = 1'b0;
            cyc++;
            if (did_abort) begin
                model_release();
                exp_q.delete();
            end
        end
        check({tag, "_dump_bounded"}, cyc < 300, 1);
        check({tag, "_handshakes"}, hs_cnt - start, did_abort ? abort_after : (accepted ? n : 0));
        check({tag, "_dump_valid_end"}, dump_valid, 0);
        check({tag, "_dump_last_end"}, dump_last, 0);
        check({tag, "_dump_inst_end"}, dump_inst, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        check("rst_halt", halt, 0);
        check("rst_count", count, 0);
        check("rst_dump_valid", dump_valid, 0);
        reset = 1'b1;
        tick();
        check_model("post_reset");

        // Simple halt
        retire(32'h8000_0000, $urandom, 0, 0);
        retire(32'h8000_0004, $urandom, 0, 0);
        retire(32'h8000_0008, $urandom, 0, 0);
        retire(32'h8000_000C, 32'h0010_0073, 1, 0);
        check("simple_halt", halt, 1);
        check("simple_cause", halt_cause, 1);
        check("simple_halt_pc", halt_pc, 32'h8000_000C);
        check("simple_count", count, 4);
        do_dump("simple", 0, -1);
        check("simple_still_halted", halt, 1);
        do_resume();
        check_model("simple_resume");

        // Wrap
        for (int k = 0; k < 6; k++) retire(32'h100 + 32'(4 * k), $urandom, k == 5, 0);
        check("wrap_count", count, 4);
        check("wrap_oldest_model", hist[0].pc, 32'h108);
        do_dump("wrap", 0, -1);

        // Backpressure, then replay
        do_dump("bp1", 1, -1);
        check("bp_halted", halt, 1);
        do_dump("bp2", 1, -1);
        check_model("bp_after");

        // Reset mid-dump
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        exp_q.push_back('{hist[0].pc, hist[0].inst, 1'b0});
        dump_ready = 1'b1;
        tick();
        dump_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_halt", halt, 0);
        check("mid_rst_cause", halt_cause, 0);
        check("mid_rst_halt_pc", halt_pc, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_dump_valid", dump_valid, 0);
        check("mid_rst_dump_pc", dump_pc, 0);
        check("mid_rst_dump_inst", dump_inst, 0);
        check("mid_rst_dump_last", dump_last, 0);
        model_release();
        exp_q.delete();
        tick();
        reset = 1'b1;
        tick();
        check_model("after_mid_rst");

        // Simultaneous flags, then dump_start + resume together
        retire(32'h200, $urandom, 1, 1);
        check("both_cause", halt_cause, 2);
        check("both_halt_pc", halt_pc, 32'h200);
        dump_start = 1'b1;
        resume     = 1'b1;
        tick();
        dump_start = 1'b0;
        resume     = 1'b0;
        model_release();
        check_model("start_and_resume");

        // Abort after the second handshake
        for (int k = 0; k < 4; k++) retire(32'h300 + 32'(4 * k), $urandom, k == 3, 0);
        do_dump("abort", 0, 2);
        check("abort_halt", halt, 0);
        retire(32'h400, $urandom, 0, 0);
        check("abort_recorded_count", count, 1);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            int burst;
            burst = $urandom_range(1, 10);
            for (int b = 0; b < burst && !m_halted; b++) begin
                if ($urandom_range(0, 3) == 0) tick();
                retire({$urandom_range(0, 32'hFFFF), 2'b00}, $urandom,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
            end
            if ($urandom_range(0, 4) == 0) do_dump("rnd_run", 2, -1);
            check_model("rnd_burst");
            if (m_halted) begin
                do_dump("rnd", 2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : -1);
                if (m_halted && $urandom_range(0, 1) == 0) do_dump("rnd_replay", 2, -1);
                check_model("rnd_dumped");
                if (m_halted) do_resume();
                check_model("rnd_resumed");
            end
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Synthesizable retire-side debug block fed by the same commit-stage signals that drive the simulation-only `Dbg` hook (`valid`, `pc`, `inst`, `is_ebreak`, `is_invalid`). It records the last DEPTH retired instructions in a ring buffer. On `ebreak` or an invalid instruction it raises a registered `halt` to stall the core. While halted, an external debug agent can drain the recorded history oldest-first over a valid/ready stream, then release the core with `resume`.

## Interface
- `DEPTH`, 16: ring-buffer entries; power of two, ≥ 2.
- `XLEN`, 32: width of `pc` and `inst`.

- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid`  in  1  one instruction retires this cycle.
- `pc`  in  XLEN  PC of the retiring instruction.
- `inst`  in  XLEN  encoding of the retiring instruction.
- `is_ebreak`  in  1  retiring instruction is `ebreak`; qualified by `valid`.
- `is_invalid`  in  1  retiring instruction is illegal; qualified by `valid`.
- `halt`  out  1  core must stop retiring.
- `halt_cause`  out  2  0 = none, 1 = ebreak, 2 = invalid.
- `halt_pc`  out  XLEN  PC of the instruction that caused the halt.
- `count`  out  clog2(DEPTH+1)  number of valid entries.
- `dump_start`  in  1  request a history dump; honoured only in HALTED.
- `resume`  in  1  clear the halt and the history.
- `dump_valid`  out  1  a dump entry is presented.
- `dump_ready`  in  1  consumer accepts the presented entry.
- `dump_pc`  out  XLEN  PC of the presented entry; 0 when `dump_valid` = 0.
- `dump_inst`  out  XLEN  instruction of the presented entry; 0 when `dump_valid` = 0.
- `dump_last`  out  1  presented entry is the newest; 0 when `dump_valid` = 0.

## Operation
- The block has three states: RUN, HALTED and DUMP. Reset enters RUN with `wptr` = 0 and `count` = 0. Every output resets to 0. Ring contents are not reset.
- **RUN:**
  - When `valid` = 1, write {`pc`, `inst`} at `wptr`. `wptr` then increments modulo DEPTH. `count` increments and saturates at DEPTH; once full, the oldest entry is overwritten.
  - When `valid` = 1 and (`is_ebreak` or `is_invalid`), the entry is still recorded and the state moves to HALTED. `halt` goes to 1, `halt_pc` takes `pc`, and `halt_cause` is set. Invalid takes priority: if both flags are set, `halt_cause` = 2.
- **HALTED / DUMP:** `valid` is ignored. The core is stalled, and a bench assertion flags any `valid` received in these states.
- **HALTED:**
  - If `resume` = 1, go to RUN. `halt`, `halt_cause`, `halt_pc` and `count` clear to 0; `wptr` is kept.
  - Otherwise, if `dump_start` = 1 and `count` > 0, go to DUMP. Load `rptr` = (`wptr` − `count`) mod DEPTH and `remaining` = `count`.
  - `dump_start` with `count` = 0 is a no-op.
  - If `resume` and `dump_start` are asserted together, `resume` wins.
- **DUMP:**
  - `dump_valid` = 1. `dump_pc` and `dump_inst` are a combinational read of the ring at `rptr`. `dump_last` = (`remaining` == 1).
  - On each handshake (`dump_valid` & `dump_ready`), `rptr` increments modulo DEPTH and `remaining` decrements.
  - The handshake on the `dump_last` entry returns the state to HALTED. `count` is unchanged, so a second `dump_start` replays the same history.
  - `resume` in DUMP aborts the dump and takes the same action as `resume` in HALTED.
- `dump_start` in RUN or DUMP is ignored.
- All pointer arithmetic wraps modulo DEPTH, using clog2(DEPTH)-bit pointers.

## Timing
- `halt`, `halt_cause` and `halt_pc` are registered and appear on the clock edge that retires the trapping instruction. The core sees `halt` one cycle after presenting the trapping retire.
- `dump_start` to `dump_valid` = 1: one edge.
- Dump throughput is one entry per cycle while `dump_ready` = 1.
- While `dump_ready` = 0, the presented entry and `dump_last` are held stable.
- `dump_valid` drops on the edge that accepts the last entry, or on a `resume`.
- `reset` assertion clears all outputs immediately, without waiting for a clock edge, in any state including mid-dump. Deassertion is synchronized externally.

## Structure
- Shared package `dbg_pkg` holds:
  - the state enum (RUN, HALTED, DUMP);
  - the cause constants `CAUSE_NONE` = 0, `CAUSE_EBREAK` = 1, `CAUSE_INVALID` = 2.
- Sub-module `trace_ram`: a DEPTH × 2·XLEN register array with one synchronous write port and one asynchronous read port, and no reset. All control logic stays in `retire_trace_buffer`.

## Test plan
- **Reset:** assert `reset` = 0 mid-stream. Required: `halt`, `halt_cause`, `halt_pc`, `count`, `dump_valid`, `dump_pc`, `dump_inst` and `dump_last` all read 0 before the next edge.
- **Simple halt (DEPTH = 4):** retire PCs 0x80000000, 0x80000004 and 0x80000008, then an `ebreak` at 0x8000000C. Required:
  - after the edge: `halt` = 1, `halt_cause` = 1, `halt_pc` = 0x8000000C, `count` = 4;
  - the dump then yields the four PCs in that order, with `dump_last` only on 0x8000000C.
- **Wrap:** with DEPTH = 4, retire six instructions at 0x100, 0x104, …, 0x114, the last being an `ebreak`. Required: the dump yields 0x108, 0x10C, 0x110, 0x114, and `count` = 4.
- **Backpressure:** during a dump, drive `dump_ready` with the pattern 1, 0, 0, 1, 0, 1, 1. Required:
  - exactly four handshakes, with data held constant while `dump_ready` = 0;
  - return to HALTED after the last handshake;
  - a second `dump_start` replays an identical sequence.
- **Simultaneous events:** retire with `is_ebreak` = `is_invalid` = 1 at 0x200. Required: `halt_cause` = 2 and `halt_pc` = 0x200. Then assert `dump_start` and `resume` together. Required: state RUN, `halt` = 0, `count` = 0, `dump_valid` = 0.
- **Abort:** assert `resume` after the second dump handshake. Required: `dump_valid` = 0 next cycle and `halt` = 0. A following retire with `valid` = 1 is recorded, giving `count` = 1.
